pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues single outstanding instruction-memory
// requests, hands fetched words to decode, and handles jump/branch redirects,
// including draining a request that was in flight when the redirect arrived.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        flush_out,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_flush;
  logic        r_misalign;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_addr_nxt;
  logic        w_req_nxt;
  logic        w_valid_nxt;
  logic [31:0] w_if_pc_nxt;
  logic [31:0] w_if_instr_nxt;
  logic        w_flush_nxt;
  logic        w_misalign_nxt;
  logic        w_ack;
  logic [31:0] w_target;

  // An acknowledge only counts while a request is actually on the bus; this
  // also drops acks that arrive in HOLD or right after reset.
  assign w_ack    = imem_ack & r_req;
  // Redirect target with bits [1:0] cleared; bit 1 is reported, not honoured.
  assign w_target = {redirect_pc[31:2], 2'b00};
  // Request stays up in FETCH and DRAIN; it is registered so reset forces it low.
  assign w_req_nxt = (w_state_nxt != HOLD);

  // Next-state and next-output decode; redirect outranks every other event.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_addr_nxt     = r_addr;
    w_valid_nxt    = r_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_flush_nxt    = 1'b0;
    w_misalign_nxt = 1'b0;
    if (redirect_valid) begin
      w_flush_nxt    = 1'b1;
      w_misalign_nxt = redirect_pc[1];
      w_pc_nxt       = w_target;
      w_valid_nxt    = 1'b0;
      case (r_state)
        FETCH: begin
          if (r_req && !w_ack) begin
            // Request still in flight: keep it on the bus until it completes.
            w_state_nxt = DRAIN;
          end else begin
            w_state_nxt = FETCH;
            w_addr_nxt  = w_target;
          end
        end
        HOLD: begin
          w_state_nxt = FETCH;
          w_addr_nxt  = w_target;
        end
        DRAIN: begin
          if (w_ack) begin
            // The stale request completes in this very cycle, so nothing is
            // left to drain; start fetching the newest target.
            w_state_nxt = FETCH;
            w_addr_nxt  = w_target;
          end else begin
            w_state_nxt = DRAIN;
          end
        end
        default: begin
          w_state_nxt = FETCH;
          w_addr_nxt  = w_target;
        end
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ack) begin
            w_if_instr_nxt = imem_rdata;
            w_if_pc_nxt    = r_pc;
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = r_pc + 32'd4;
            w_state_nxt    = HOLD;
          end else begin
            w_state_nxt = FETCH;
          end
        end
        HOLD: begin
          if (if_ready) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = FETCH;
            w_addr_nxt  = r_pc;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        DRAIN: begin
          if (w_ack) begin
            w_state_nxt = FETCH;
            w_addr_nxt  = r_pc;
          end else begin
            w_state_nxt = DRAIN;
          end
        end
        default: begin
          w_state_nxt = FETCH;
          w_valid_nxt = 1'b0;
          w_addr_nxt  = r_pc;
        end
      endcase
    end
  end

  // State, PC and all outputs are registered; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_if_pc    <= 32'h0000_0000;
      r_if_instr <= 32'h0000_0000;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= w_req_nxt;
      r_valid    <= w_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_flush    <= w_flush_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_addr;
  assign if_valid     = r_valid;
  assign if_pc        = r_if_pc;
  assign if_instr     = r_if_instr;
  assign flush_out    = r_flush;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a transaction-level model predicts the
// request addresses and delivered instructions; a separate monitor compares.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush_out;
  logic        misalign_err;

  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_valid;
  logic [31:0] wr_if_pc;
  logic [31:0] wr_if_instr;
  logic        wr_flush;
  logic        wr_mis;

  always #5 clk = ~clk;

  pc_fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .flush_out(flush_out), .misalign_err(misalign_err)
  );

  // Second instance with the top-of-memory reset PC; memory acks every request at once.
  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .imem_req(wr_req), .imem_addr(wr_addr), .imem_ack(wr_req), .imem_rdata(32'h0000_0013),
    .if_valid(wr_valid), .if_pc(wr_if_pc), .if_instr(wr_if_instr), .if_ready(1'b1),
    .flush_out(wr_flush), .misalign_err(wr_mis)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] q_addr[$];
  logic [63:0] q_deliv[$];

  // Reference model: a request is outstanding (busy), possibly invalidated by
  // a redirect (dead); a fetched instruction may be waiting for decode (held).
  logic        m_busy, m_dead, m_held;
  logic [31:0] m_pc, m_req_addr;
  logic        exp_flush, exp_mis;
  logic        fixed_data;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_dead = 1'b0; m_held = 1'b0;
    m_pc = 32'h0000_0000; m_req_addr = 32'h0000_0000;
    exp_flush = 1'b0; exp_mis = 1'b0;
    q_addr.delete();
    q_deliv.delete();
  endtask

  task automatic issue(input logic [31:0] a);
    q_addr.push_back(a);
    m_busy = 1'b1; m_dead = 1'b0; m_req_addr = a; m_pc = a;
  endtask

  // One clock edge of the reference model, using the inputs presented at that edge.
  task automatic model_step();
    logic        ack_eff;
    logic [31:0] t;
    ack_eff   = imem_ack && m_busy;
    exp_flush = redirect_valid;
    exp_mis   = redirect_valid && redirect_pc[1];
    if (redirect_valid) begin
      t = {redirect_pc[31:2], 2'b00};
      m_held = 1'b0;
      if (m_busy && !ack_eff) begin
        m_dead = 1'b1;
        m_pc   = t;
      end else begin
        issue(t);
      end
    end else if (ack_eff) begin
      if (m_dead) begin
        issue(m_pc);
      end else begin
        m_held = 1'b1;
        q_deliv.push_back({m_req_addr, fixed_data ? 32'h0000_0013 : mem_fn(m_req_addr)});
        m_busy = 1'b0;
        m_pc   = m_req_addr + 32'd4;
      end
    end else if (m_held) begin
      if (if_ready) begin
        m_held = 1'b0;
        issue(m_pc);
      end
    end else if (!m_busy) begin
      issue(m_pc);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic ack, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    imem_ack       = ack;
    imem_rdata     = ack ? (fixed_data ? 32'h0000_0013 : mem_fn(imem_addr)) : 32'hDEAD_BEEF;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic go_hold();
    for (int i = 0; i < 8 && !m_held; i++) step(1'b0, 32'h0, m_busy, 1'b0);
    if (!m_held) fail_msg("reach_hold_timeout");
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    logic        p_req, p_ack, p_valid;
    logic [31:0] p_addr, p_pc, p_instr;
    logic [31:0] ea;
    logic [63:0] ed;
    p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0;
    p_addr = 32'h0; p_pc = 32'h0; p_instr = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0;
      end else begin
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_held});
        chk("flush_out", {31'd0, flush_out}, {31'd0, exp_flush});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
        if (imem_req && (!p_req || p_ack)) begin
          if (q_addr.size() == 0) fail_msg("unexpected_request");
          else begin
            ea = q_addr.pop_front();
            chk("req_addr", imem_addr, ea);
          end
        end else if (imem_req) begin
          chk("addr_stable", imem_addr, p_addr);
        end
        if (if_valid && !p_valid) begin
          if (q_deliv.size() == 0) fail_msg("unexpected_delivery");
          else begin
            ed = q_deliv.pop_front();
            chk("if_pc", if_pc, ed[63:32]);
            chk("if_instr", if_instr, ed[31:0]);
          end
        end else if (if_valid) begin
          chk("if_pc_stable", if_pc, p_pc);
          chk("if_instr_stable", if_instr, p_instr);
        end
        p_req = imem_req; p_ack = imem_ack; p_valid = if_valid;
        p_addr = imem_addr; p_pc = if_pc; p_instr = if_instr;
      end
    end
  end

  // Wrap instance: the first two fetch addresses after reset release.
  initial begin
    logic [31:0] got[2];
    int n;
    n = 0;
    @(posedge rst_n);
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (wr_req) begin
        got[n] = wr_addr;
        n++;
      end
    end
    if (n < 2) fail_msg("wrap_timeout");
    else begin
      chk("wrap_addr0", got[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", got[1], 32'h0000_0000);
    end
  end

  // Stimulus: directed scenarios, then random traffic, then reset mid-drain.
  initial begin
    logic [31:0] old;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
    imem_rdata = 32'h0; if_ready = 1'b0; fixed_data = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush_out}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch with data 0x13 and decode always ready.
    repeat (9) step(1'b0, 32'h0, m_busy, 1'b1);

    // Backpressure: decode stalls for five cycles while an instruction is held.
    go_hold();
    repeat (5) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("bp_imem_req", {31'd0, imem_req}, 32'd0);
      chk("bp_if_valid", {31'd0, if_valid}, 32'd1);
    end

    // Drain: redirect while the request is outstanding, ack arrives later.
    fixed_data = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    old = m_req_addr;
    step(1'b1, 32'h0000_0101, 1'b0, 1'b1);
    chk("drain_flush", {31'd0, flush_out}, 32'd1);
    chk("drain_addr", imem_addr, old);
    repeat (2) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("drain_flush_once", {31'd0, flush_out}, 32'd0);
      chk("drain_addr_hold", imem_addr, old);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drain_next_addr", imem_addr, 32'h0000_0100);
    chk("drain_no_stale", {31'd0, if_valid}, 32'd0);

    // Squash in HOLD with decode ready in the same cycle.
    go_hold();
    step(1'b1, 32'h0000_0040, 1'b0, 1'b1);
    chk("squash_valid", {31'd0, if_valid}, 32'd0);
    chk("squash_addr", imem_addr, 32'h0000_0040);

    // Misaligned redirect target.
    go_hold();
    step(1'b1, 32'h0000_0022, 1'b0, 1'b0);
    chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
    chk("mis_addr", imem_addr, 32'h0000_0020);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mis_once", {31'd0, misalign_err}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) == 0, $urandom, m_busy && ($urandom_range(0, 1) == 1),
           $urandom_range(0, 2) != 0);
    end

    // Reset asserted mid-drain; a late ack must be ignored.
    for (int i = 0; i < 8 && !m_busy; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    model_reset();
    redirect_valid = 1'b0;
    imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0000_0000);
    repeat (6) step(1'b0, 32'h0, m_busy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
